// File: rtl/spc_ram_arbiter_pkg.sv
// Shared types for the audio RAM arbiter: port indices, request bundle, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spc_ram_pkg;

   // Default RAM geometry (64 KiB, byte wide)
   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 8;

   // Number of requesters and width of each starvation counter
   localparam int NUM_PORTS  = 3;
   localparam int WAIT_WIDTH = 4;

   // Bit positions of each requester inside the per-port vectors
   localparam int IDX_DSP  = 0;
   localparam int IDX_CPU  = 1;
   localparam int IDX_HOST = 2;

   // Who owns the RAM port (grant) or the completion cycle (ack owner)
   typedef enum logic [1:0] {
      PORT_NONE = 2'd0,
      PORT_DSP  = 2'd1,
      PORT_CPU  = 2'd2,
      PORT_HOST = 2'd3
   } port_e;

   // One requester's access as presented to the RAM
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] address;
      logic [DATA_WIDTH-1:0] data;
      logic                  write_enable;
   } ram_req_t;

   // Keep only the lowest set bit: index 0 (DSP) is the highest priority
   function automatic logic [NUM_PORTS-1:0] first_one(input logic [NUM_PORTS-1:0] v);
      logic [NUM_PORTS-1:0] r;
      r = '0;
      if (v[IDX_DSP])       r[IDX_DSP]  = 1'b1;
      else if (v[IDX_CPU])  r[IDX_CPU]  = 1'b1;
      else if (v[IDX_HOST]) r[IDX_HOST] = 1'b1;
      return r;
   endfunction

   // Convert a one-hot (or empty) grant vector into a port index
   function automatic port_e vec_to_port(input logic [NUM_PORTS-1:0] v);
      port_e p;
      p = PORT_NONE;
      if (v[IDX_DSP])       p = PORT_DSP;
      else if (v[IDX_CPU])  p = PORT_CPU;
      else if (v[IDX_HOST]) p = PORT_HOST;
      return p;
   endfunction

endpackage

// File: rtl/spc_ram_arb_pick.sv
// Picks at most one RAM winner per cycle: boosted ports first, then DSP > CPU > HOST.
// Latency: grant is combinational in the request cycle; wait counters update at the clock edge.
// Backpressure: a port is not eligible in its own ack cycle; losers wait, bounded by MAX_WAIT.
module spc_ram_arb_pick
   import spc_ram_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NUM_PORTS-1:0] i_req,
   input  logic [NUM_PORTS-1:0] i_ack,
   output logic [NUM_PORTS-1:0] o_grant_vec,
   output port_e                o_grant
);

   localparam logic [WAIT_WIDTH-1:0] L_MAX_WAIT = WAIT_WIDTH'(MAX_WAIT);

   logic [WAIT_WIDTH-1:0] r_wait [NUM_PORTS];
   logic [NUM_PORTS-1:0]  w_elig;
   logic [NUM_PORTS-1:0]  w_boost;
   logic [NUM_PORTS-1:0]  w_grant_vec;

   // A port in its ack cycle has already been served for this request
   assign w_elig = i_req & ~i_ack;

   // Boost flags: counter has reached the saturation point
   always_comb begin
      w_boost = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_boost[i] = w_elig[i] && (r_wait[i] == L_MAX_WAIT);
      end
   end

   // Boosted class wins outright; fixed priority resolves ties inside each class
   always_comb begin
      w_grant_vec = '0;
      if (|w_boost) begin
         w_grant_vec = first_one(w_boost);
      end else begin
         w_grant_vec = first_one(w_elig);
      end
   end

   assign o_grant_vec = w_grant_vec;
   assign o_grant     = vec_to_port(w_grant_vec);

   // Wait counters: count losing eligible cycles, saturate, clear on grant or idle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            r_wait[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!i_req[i] || w_grant_vec[i]) begin
               r_wait[i] <= '0;
            end else if (w_elig[i] && (r_wait[i] != L_MAX_WAIT)) begin
               r_wait[i] <= r_wait[i] + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spc_ram_arbiter.sv
// Three-port (DSP/CPU/HOST) arbiter serialising accesses onto one synchronous audio RAM port.
// Latency: grant and RAM drive in cycle N, ack (and read data) exactly in cycle N+1.
// Backpressure: requesters hold req until ack; starvation guard bounds wait to MAX_WAIT+2 cycles.
module spc_ram_arbiter #(
   parameter int ADDR_WIDTH = spc_ram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = spc_ram_pkg::DATA_WIDTH,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   // DSP requester
   input  logic                  dsp_req,
   input  logic [ADDR_WIDTH-1:0] dsp_address,
   input  logic [DATA_WIDTH-1:0] dsp_data_in,
   input  logic                  dsp_write_enable,
   output logic [DATA_WIDTH-1:0] dsp_data_out,
   output logic                  dsp_ack,
   // CPU requester
   input  logic                  cpu_req,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [DATA_WIDTH-1:0] cpu_data_in,
   input  logic                  cpu_write_enable,
   output logic [DATA_WIDTH-1:0] cpu_data_out,
   output logic                  cpu_ack,
   // Host/debug requester
   input  logic                  host_req,
   input  logic [ADDR_WIDTH-1:0] host_address,
   input  logic [DATA_WIDTH-1:0] host_data_in,
   input  logic                  host_write_enable,
   output logic [DATA_WIDTH-1:0] host_data_out,
   output logic                  host_ack,
   // RAM port
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   output logic                  ram_write_enable,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   import spc_ram_pkg::*;

   // The request bundle is sized from the package; the width parameters
   // are expected to stay at the package defaults.
   ram_req_t             w_req [NUM_PORTS];
   ram_req_t             w_sel;
   logic [NUM_PORTS-1:0] w_req_vec;
   logic [NUM_PORTS-1:0] w_ack_vec;
   logic [NUM_PORTS-1:0] w_grant_vec;
   port_e                w_grant;
   port_e                r_ack_owner;

   assign w_req[IDX_DSP]  = '{address: dsp_address,  data: dsp_data_in,  write_enable: dsp_write_enable};
   assign w_req[IDX_CPU]  = '{address: cpu_address,  data: cpu_data_in,  write_enable: cpu_write_enable};
   assign w_req[IDX_HOST] = '{address: host_address, data: host_data_in, write_enable: host_write_enable};

   assign w_req_vec = {host_req, cpu_req, dsp_req};

   // Acks come straight from the registered owner; one owner means one ack
   assign w_ack_vec[IDX_DSP]  = (r_ack_owner == PORT_DSP);
   assign w_ack_vec[IDX_CPU]  = (r_ack_owner == PORT_CPU);
   assign w_ack_vec[IDX_HOST] = (r_ack_owner == PORT_HOST);

   spc_ram_arb_pick #(
      .MAX_WAIT (MAX_WAIT)
   ) u_pick (
      .clock       (clock),
      .reset_n     (reset_n),
      .i_req       (w_req_vec),
      .i_ack       (w_ack_vec),
      .o_grant_vec (w_grant_vec),
      .o_grant     (w_grant)
   );

   // Route the winner onto the RAM port; idle cycles issue a harmless read of 0
   always_comb begin
      w_sel = '0;
      case (w_grant)
         PORT_DSP:  w_sel = w_req[IDX_DSP];
         PORT_CPU:  w_sel = w_req[IDX_CPU];
         PORT_HOST: w_sel = w_req[IDX_HOST];
         default:   w_sel = '0;
      endcase
   end

   assign ram_address      = w_sel.address;
   assign ram_data_in      = w_sel.data;
   // Reset gates the write strobe so nothing is committed while the block is held
   assign ram_write_enable = w_sel.write_enable & reset_n;

   // Remember who was granted so the next cycle's ack and read data go to them
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ack_owner <= PORT_NONE;
      end else begin
         r_ack_owner <= w_grant;
      end
   end

   assign dsp_ack  = w_ack_vec[IDX_DSP];
   assign cpu_ack  = w_ack_vec[IDX_CPU];
   assign host_ack = w_ack_vec[IDX_HOST];

   // Read data is only presented to the ack owner; everyone else sees zero
   assign dsp_data_out  = w_ack_vec[IDX_DSP]  ? ram_data_out : '0;
   assign cpu_data_out  = w_ack_vec[IDX_CPU]  ? ram_data_out : '0;
   assign host_data_out = w_ack_vec[IDX_HOST] ? ram_data_out : '0;

   // Tie-off for the unused grant vector bits (grant index is used for muxing)
   logic w_unused;
   assign w_unused = ^w_grant_vec;

endmodule

// File: tb/tb_spc_ram_arbiter.sv
// Directed bench for spc_ram_arbiter with a behavioural 64 KiB synchronous RAM.
module tb_spc_ram_arbiter;

   logic        clock;
   logic        reset_n;
   logic        dsp_req, cpu_req, host_req;
   logic [15:0] dsp_address, cpu_address, host_address;
   logic [7:0]  dsp_data_in, cpu_data_in, host_data_in;
   logic        dsp_write_enable, cpu_write_enable, host_write_enable;
   logic [7:0]  dsp_data_out, cpu_data_out, host_data_out;
   logic        dsp_ack, cpu_ack, host_ack;
   logic [15:0] ram_address;
   logic [7:0]  ram_data_in;
   logic        ram_write_enable;
   logic [7:0]  ram_data_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [65536];

   spc_ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .MAX_WAIT(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .dsp_req(dsp_req), .dsp_address(dsp_address), .dsp_data_in(dsp_data_in),
      .dsp_write_enable(dsp_write_enable), .dsp_data_out(dsp_data_out), .dsp_ack(dsp_ack),
      .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_data_in(cpu_data_in),
      .cpu_write_enable(cpu_write_enable), .cpu_data_out(cpu_data_out), .cpu_ack(cpu_ack),
      .host_req(host_req), .host_address(host_address), .host_data_in(host_data_in),
      .host_write_enable(host_write_enable), .host_data_out(host_data_out), .host_ack(host_ack),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous RAM: write at the edge, read data registered for the next cycle
   always @(posedge clock) begin
      if (ram_write_enable) mem[ram_address] <= ram_data_in;
      ram_data_out <= mem[ram_address];
   end

   wire [2:0] acks = {host_ack, cpu_ack, dsp_ack};

   // Protocol monitor: a pending request must be held unchanged until its ack
   logic [2:0]  p_req = '0, p_ack = '0;
   logic [24:0] p_key [3];
   logic        p_rst = 1'b0;
   wire  [2:0]  m_req = {host_req, cpu_req, dsp_req};
   wire  [24:0] m_key [3];
   assign m_key[0] = {dsp_address, dsp_data_in, dsp_write_enable};
   assign m_key[1] = {cpu_address, cpu_data_in, cpu_write_enable};
   assign m_key[2] = {host_address, host_data_in, host_write_enable};

   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (p_rst && reset_n && p_req[i] && !p_ack[i] && !acks[i] &&
             (!m_req[i] || m_key[i] !== p_key[i])) begin
            n_fail++;
            $display("FAIL protocol port %0d: request dropped or changed before ack", i);
         end
         p_key[i] = m_key[i];
      end
      p_req = m_req;
      p_ack = acks;
      p_rst = reset_n;
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input int p, input logic req, input logic [15:0] a,
                        input logic [7:0] d, input logic we);
      case (p)
         0: begin dsp_req = req;  dsp_address = a;  dsp_data_in = d;  dsp_write_enable = we;  end
         1: begin cpu_req = req;  cpu_address = a;  cpu_data_in = d;  cpu_write_enable = we;  end
         default: begin host_req = req; host_address = a; host_data_in = d; host_write_enable = we; end
      endcase
   endtask

   task automatic idle(input int n);
      drive(0, 0, 16'h0, 8'h0, 0);
      drive(1, 0, 16'h0, 8'h0, 0);
      drive(2, 0, 16'h0, 8'h0, 0);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle(0);
      drive(1, 1, 16'h0033, 8'hEE, 1);
      cyc();
      @(negedge clock);
      n_checks++; if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", ram_write_enable); end
      n_checks++; if (acks !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", acks); end
      n_checks++; if ({dsp_data_out, cpu_data_out, host_data_out} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {dsp_data_out, cpu_data_out, host_data_out}); end
      idle(1);
      reset_n = 1'b1;
      idle(2);
   endtask

   task automatic test_idle();
      @(negedge clock);
      n_checks++; if ({ram_address, ram_data_in, ram_write_enable} !== 25'h0) begin n_fail++; $display("FAIL idle_ram: got %h want 0", {ram_address, ram_data_in, ram_write_enable}); end
      n_checks++; if (acks !== 3'b000) begin n_fail++; $display("FAIL idle_acks: got %b want 000", acks); end
      cyc();
   endtask

   task automatic test_cpu_write_read();
      drive(1, 1, 16'h1234, 8'hA5, 1);
      @(negedge clock);
      n_checks++; if (ram_address !== 16'h1234 || ram_write_enable !== 1'b1 || ram_data_in !== 8'hA5) begin n_fail++; $display("FAIL wr_issue: got %h/%b/%h want 1234/1/a5", ram_address, ram_write_enable, ram_data_in); end
      cyc();
      drive(1, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", cpu_ack); end
      cyc();
      drive(1, 1, 16'h1234, 8'h00, 0);
      @(negedge clock);
      n_checks++; if (cpu_ack !== 1'b0 || ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL rd_issue: got ack %b we %b want 0/0", cpu_ack, ram_write_enable); end
      cyc();
      drive(1, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (cpu_ack !== 1'b1 || cpu_data_out !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got ack %b data %h want 1/a5", cpu_ack, cpu_data_out); end
      idle(2);
   endtask

   task automatic test_two_ports();
      mem[16'h0200] = 8'h11;
      mem[16'h0300] = 8'h22;
      drive(0, 1, 16'h0200, 8'h00, 0);
      drive(1, 1, 16'h0300, 8'h00, 0);
      @(negedge clock);
      n_checks++; if (ram_address !== 16'h0200) begin n_fail++; $display("FAIL two_addr0: got %h want 0200", ram_address); end
      cyc();
      drive(0, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (acks !== 3'b001 || dsp_data_out !== 8'h11) begin n_fail++; $display("FAIL two_dsp: got acks %b data %h want 001/11", acks, dsp_data_out); end
      n_checks++; if (ram_address !== 16'h0300) begin n_fail++; $display("FAIL two_addr1: got %h want 0300", ram_address); end
      cyc();
      drive(1, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (acks !== 3'b010 || cpu_data_out !== 8'h22 || dsp_data_out !== 8'h00) begin n_fail++; $display("FAIL two_cpu: got acks %b cpu %h dsp %h want 010/22/00", acks, cpu_data_out, dsp_data_out); end
      idle(2);
   endtask

   task automatic test_write_then_read();
      drive(1, 1, 16'h00F0, 8'h5A, 1);
      drive(0, 1, 16'h00F0, 8'h00, 0);
      @(negedge clock);
      n_checks++; if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL wtr_prio: got we %b want 0", ram_write_enable); end
      cyc();
      drive(0, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (dsp_ack !== 1'b1 || dsp_data_out !== 8'h00) begin n_fail++; $display("FAIL wtr_old: got ack %b data %h want 1/00", dsp_ack, dsp_data_out); end
      n_checks++; if (ram_write_enable !== 1'b1) begin n_fail++; $display("FAIL wtr_wr: got we %b want 1", ram_write_enable); end
      cyc();
      drive(1, 0, 16'h0, 8'h0, 0);
      drive(0, 1, 16'h00F0, 8'h00, 0);
      @(negedge clock);
      n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL wtr_cack: got %b want 1", cpu_ack); end
      cyc();
      drive(0, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (dsp_ack !== 1'b1 || dsp_data_out !== 8'h5A) begin n_fail++; $display("FAIL wtr_new: got ack %b data %h want 1/5a", dsp_ack, dsp_data_out); end
      idle(2);
   endtask

   logic [15:0] st_addr [8] = '{16'h1000, 16'h2000, 16'h1000, 16'h2000, 16'h4000, 16'h1000, 16'h2000, 16'h1000};
   logic [2:0]  st_ack  [8] = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};

   task automatic test_starvation();
      mem[16'h4000] = 8'h77;
      drive(0, 1, 16'h1000, 8'h00, 0);
      drive(1, 1, 16'h2000, 8'h00, 0);
      drive(2, 1, 16'h4000, 8'h00, 0);
      for (int c = 0; c < 8; c++) begin
         if (c == 5) drive(2, 0, 16'h0, 8'h0, 0);
         @(negedge clock);
         n_checks++; if (ram_address !== st_addr[c]) begin n_fail++; $display("FAIL starve_addr c%0d: got %h want %h", c, ram_address, st_addr[c]); end
         n_checks++; if (acks !== st_ack[c]) begin n_fail++; $display("FAIL starve_ack c%0d: got %b want %b", c, acks, st_ack[c]); end
         if (c == 5) begin
            n_checks++; if (host_data_out !== 8'h77) begin n_fail++; $display("FAIL starve_hdata: got %h want 77", host_data_out); end
         end
         cyc();
      end
      idle(2);
   endtask

   task automatic test_reset_in_flight();
      drive(1, 1, 16'h0010, 8'h00, 0);
      @(negedge clock);
      n_checks++; if (ram_address !== 16'h0010) begin n_fail++; $display("FAIL rst_issue: got %h want 0010", ram_address); end
      cyc();
      drive(1, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack: got %b want 1", cpu_ack); end
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (acks !== 3'b000 || cpu_data_out !== 8'h00) begin n_fail++; $display("FAIL rst_drop: got acks %b data %h want 000/00", acks, cpu_data_out); end
      drive(2, 1, 16'h0050, 8'h99, 1);
      #1;
      n_checks++; if (ram_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", ram_write_enable); end
      cyc();
      @(negedge clock);
      n_checks++; if (acks !== 3'b000) begin n_fail++; $display("FAIL rst_hold_acks: got %b want 000", acks); end
      drive(2, 0, 16'h0, 8'h0, 0);
      cyc();
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++; if (acks !== 3'b000 || mem[16'h0050] !== 8'h00) begin n_fail++; $display("FAIL rst_release: got acks %b mem %h want 000/00", acks, mem[16'h0050]); end
      cyc();
      drive(0, 1, 16'h0100, 8'h00, 0);
      drive(1, 1, 16'h0101, 8'h00, 0);
      drive(2, 1, 16'h0102, 8'h00, 0);
      @(negedge clock);
      n_checks++; if (ram_address !== 16'h0100 || acks !== 3'b000) begin n_fail++; $display("FAIL rst_ord0: got %h/%b want 0100/000", ram_address, acks); end
      cyc();
      drive(0, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (ram_address !== 16'h0101 || acks !== 3'b001) begin n_fail++; $display("FAIL rst_ord1: got %h/%b want 0101/001", ram_address, acks); end
      cyc();
      drive(1, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (ram_address !== 16'h0102 || acks !== 3'b010) begin n_fail++; $display("FAIL rst_ord2: got %h/%b want 0102/010", ram_address, acks); end
      cyc();
      drive(2, 0, 16'h0, 8'h0, 0);
      @(negedge clock);
      n_checks++; if (acks !== 3'b100) begin n_fail++; $display("FAIL rst_ord3: got %b want 100", acks); end
      idle(2);
   endtask

   task automatic test_back_to_back();
      int n_acks;
      logic [7:0] k;
      n_acks = 0;
      for (int i = 0; i < 16; i++) begin
         drive(2, 1, 16'hFFC0 + 16'(i), 8'(i), 1);
         @(negedge clock);
         n_checks++; if (ram_address !== 16'hFFC0 + 16'(i) || ram_write_enable !== 1'b1) begin n_fail++; $display("FAIL b2b_issue %0d: got %h/%b", i, ram_address, ram_write_enable); end
         n_acks += int'(host_ack);
         cyc();
         drive(2, 0, 16'h0, 8'h0, 0);
         @(negedge clock);
         n_acks += int'(host_ack);
         cyc();
      end
      n_checks++; if (n_acks != 16) begin n_fail++; $display("FAIL b2b_acks: got %0d want 16", n_acks); end
      for (int j = 0; j < 3; j++) begin
         k = (j == 0) ? 8'h00 : (j == 1) ? 8'h07 : 8'h0F;
         drive(0, 1, 16'hFFC0 + 16'(k), 8'h00, 0);
         cyc();
         drive(0, 0, 16'h0, 8'h0, 0);
         @(negedge clock);
         n_checks++; if (dsp_ack !== 1'b1 || dsp_data_out !== k) begin n_fail++; $display("FAIL b2b_read %h: got ack %b data %h want 1/%h", k, dsp_ack, dsp_data_out, k); end
         cyc();
      end
      idle(2);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset();
      test_idle();
      test_cpu_write_read();
      test_two_ports();
      test_write_then_read();
      test_starvation();
      test_reset_in_flight();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
